envelope_decimator: RTL and testbench

- Sits directly downstream of the homomorphic envelope stage.
- Consumes its 32-bit Q3.12 envelope samples, qualified by its write_enable pulse.
- Boxcar-averages each block of DECIM consecutive samples into one output word, then buffers results in a small FWFT FIFO.
- The AIRISC core (or the next stage) drains the FIFO through a valid/ready handshake at its own pace.

---
 rtl/envelope_decimator.sv | 87 ++++++++
 tb/tb_envelope_decimator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/envelope_decimator.sv
// envelope_decimator: boxcar-averages DECIM envelope samples into one word and buffers results in an FWFT FIFO.
// Optional feature macro HSS_ENV_PEAK_TRACK_EN adds peak_data, the largest result produced since reset or ovf_clr.
module envelope_decimator #(
   parameter int DECIM      = 8,
   parameter int LOG2_DECIM = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [31:0]                   in_data,
   input  logic                          in_valid,
   output logic [31:0]                   out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   input  logic                          ovf_clr,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fill
`ifdef HSS_ENV_PEAK_TRACK_EN
   ,
   output logic [31:0]                   peak_data
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [31+LOG2_DECIM:0] acc_q, acc_d, sum;
   logic [LOG2_DECIM-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]            fill_q, fill_d;
   logic                   ovf_q, ovf_d;
   logic [31:0]            mem_q [FIFO_DEPTH];
   logic [31:0]            result;
   logic                   last, full, pop, push, drop;
`ifdef HSS_ENV_PEAK_TRACK_EN
   logic [31:0]            peak_q, peak_d;
`endif
   // Next-state: accumulate, detect block end, and resolve push/pop/drop against FIFO occupancy.
   always_comb begin
      sum    = acc_q + (32+LOG2_DECIM)'(in_data);
      result = 32'(sum >> LOG2_DECIM);
      last   = in_valid && (cnt_q == LOG2_DECIM'(DECIM-1));
      full   = fill_q == (AW+1)'(FIFO_DEPTH);
      pop    = (fill_q != '0) && out_ready;
      push   = last && (!full || pop);
      drop   = last && full && !pop;
      acc_d  = !in_valid ? acc_q : last ? '0 : sum;
      cnt_d  = in_valid ? cnt_q + 1'b1 : cnt_q;
      wr_d   = wr_q + AW'(push);
      rd_d   = rd_q + AW'(pop);
      fill_d = fill_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d  = drop | (ovf_q & ~ovf_clr);
`ifdef HSS_ENV_PEAK_TRACK_EN
      peak_d = ovf_clr ? (last ? result : '0) : (last && result > peak_q) ? result : peak_q;
`endif
   end
   // State registers; when full with a pop, the write lands in the slot the head just vacated.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         fill_q <= '0;
         ovf_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef HSS_ENV_PEAK_TRACK_EN
         peak_q <= '0;
`endif
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fill_q <= fill_d;
         ovf_q  <= ovf_d;
         if (push) mem_q[wr_q] <= result;
`ifdef HSS_ENV_PEAK_TRACK_EN
         peak_q <= peak_d;
`endif
      end
   end
   assign out_valid = fill_q != '0;
   assign out_data  = out_valid ? mem_q[rd_q] : '0;
   assign overflow  = ovf_q;
   assign fill      = fill_q;
`ifdef HSS_ENV_PEAK_TRACK_EN
   assign peak_data = peak_q;
`endif
endmodule

// File: tb/tb_envelope_decimator.sv
// tb_envelope_decimator: directed table-driven and sequence checks of envelope_decimator (DECIM=8, FIFO_DEPTH=4).
module tb_envelope_decimator;
   logic        CLK = 1'b0, RST = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
   logic [31:0] out_data;
   logic        out_valid, overflow;
   logic [2:0]  fill;
`ifdef HSS_ENV_PEAK_TRACK_EN
   logic [31:0] peak_data;
`endif
   int checks = 0, failures = 0;

   envelope_decimator #(.DECIM(8), .LOG2_DECIM(3), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .ovf_clr(ovf_clr), .overflow(overflow), .fill(fill)
`ifdef HSS_ENV_PEAK_TRACK_EN
      , .peak_data(peak_data)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string            name;
      logic [7:0][31:0] samp;
      logic [31:0]      exp;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic send_block(input logic [31:0] v, input logic rdy_last, input logic clr_last);
      for (int i = 0; i < 7; i++) send(v);
      out_ready = rdy_last;
      ovf_clr   = clr_last;
      send(v);
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
   endtask

   task automatic pop_check(input string n, input logic [31:0] exp);
      chk({n, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({n, "_data"}, out_data, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic clr_pulse();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         vecs[0].samp[i] = 32'h0000_1000;
         vecs[1].samp[i] = 32'(i);
         vecs[2].samp[i] = 32'hFFFF_FFFF;
         vecs[3].samp[i] = (i == 7) ? 32'h7 : 32'h0;
         vecs[4].samp[i] = (i == 0) ? 32'h8 : 32'h0;
         vecs[5].samp[i] = i[0] ? 32'h1000 : 32'h3000;
      end
      vecs[0].name = "avg_1p0";   vecs[0].exp = 32'h0000_1000;
      vecs[1].name = "trunc_0_7"; vecs[1].exp = 32'h0000_0003;
      vecs[2].name = "all_ones";  vecs[2].exp = 32'hFFFF_FFFF;
      vecs[3].name = "trunc_7";   vecs[3].exp = 32'h0000_0000;
      vecs[4].name = "exact_8";   vecs[4].exp = 32'h0000_0001;
      vecs[5].name = "alt_mix";   vecs[5].exp = 32'h0000_2000;

      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_fill", {29'd0, fill}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      RST = 1'b0;
      tick();

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 7; i++) send(vecs[v].samp[i]);
         chk({vecs[v].name, "_pre_valid"}, {31'd0, out_valid}, 32'd0);
         send(vecs[v].samp[7]);
         chk({vecs[v].name, "_fill"}, {29'd0, fill}, 32'd1);
         pop_check(vecs[v].name, vecs[v].exp);
         chk({vecs[v].name, "_post_fill"}, {29'd0, fill}, 32'd0);
      end

      for (int k = 1; k <= 5; k++) begin
         send_block(32'h100 * k, 1'b0, 1'b0);
         if (k == 4) begin
            chk("full4_fill", {29'd0, fill}, 32'd4);
            chk("full4_ovf", {31'd0, overflow}, 32'd0);
         end
      end
      chk("drop_fill", {29'd0, fill}, 32'd4);
      chk("drop_ovf", {31'd0, overflow}, 32'd1);
      clr_pulse();
      chk("clr_ovf", {31'd0, overflow}, 32'd0);
      send_block(32'h600, 1'b0, 1'b1);
      chk("set_wins_ovf", {31'd0, overflow}, 32'd1);
      chk("set_wins_fill", {29'd0, fill}, 32'd4);
      for (int k = 1; k <= 4; k++) pop_check($sformatf("drain%0d", k), 32'h100 * k);
      chk("drain_fill", {29'd0, fill}, 32'd0);
      clr_pulse();
      chk("drain_clr_ovf", {31'd0, overflow}, 32'd0);

      for (int k = 1; k <= 4; k++) send_block(32'h10 + k, 1'b0, 1'b0);
      send_block(32'h15, 1'b1, 1'b0);
      chk("fullpop_ovf", {31'd0, overflow}, 32'd0);
      chk("fullpop_fill", {29'd0, fill}, 32'd4);
      for (int k = 2; k <= 5; k++) pop_check($sformatf("fullpop%0d", k), 32'h10 + k);
      chk("fullpop_end_fill", {29'd0, fill}, 32'd0);

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("empty_pop_fill", {29'd0, fill}, 32'd0);
      chk("empty_pop_valid", {31'd0, out_valid}, 32'd0);
      send_block(32'h21, 1'b0, 1'b0);
      send_block(32'h22, 1'b1, 1'b0);
      chk("mid_pushpop_fill", {29'd0, fill}, 32'd1);
      pop_check("mid_pushpop", 32'h22);

      send_block(32'h31, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send(32'h2000);
      #2 RST = 1'b1;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_fill", {29'd0, fill}, 32'd0);
      chk("arst_data", out_data, 32'd0);
      #3 RST = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) send(32'h1000);
      chk("post_rst_fill", {29'd0, fill}, 32'd1);
      pop_check("post_rst", 32'h1000);

`ifdef HSS_ENV_PEAK_TRACK_EN
      clr_pulse();
      chk("peak_clr0", peak_data, 32'd0);
      send_block(32'h1000, 1'b0, 1'b0);
      pop_check("peak_b1", 32'h1000);
      send_block(32'h3000, 1'b0, 1'b0);
      pop_check("peak_b2", 32'h3000);
      send_block(32'h2000, 1'b0, 1'b0);
      pop_check("peak_b3", 32'h2000);
      chk("peak_max", peak_data, 32'h3000);
      clr_pulse();
      chk("peak_clr", peak_data, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
